// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencer with registered control outputs,
// ALU decoder, and the branch-qualified PC enable.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       memwrite;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   state_t state_r;
   state_t next_state_s;
   ctrl_t  ctrl_r;

   function automatic state_t next_state(input state_t s, input logic [5:0] opc);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:   n = DECODE;
         DECODE: begin
            case (opc)
               6'b100011, 6'b101011: n = MEMADR;
               6'b000000:            n = RTYPEEX;
               6'b000100:            n = BEQEX;
               6'b001000:            n = ADDIEX;
               6'b000010:            n = JEX;
               default:              n = FETCH;
            endcase
         end
         MEMADR: begin
            if (opc == 6'b100011) n = MEMRD;
            else                  n = MEMWR;
         end
         MEMRD:   n = MEMWB;
         RTYPEEX: n = RTYPEWB;
         ADDIEX:  n = ADDIWB;
         default: n = FETCH;
      endcase
      return n;
   endfunction

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         DECODE:  c.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD:   c.iord = 1'b1;
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b10;
         end
         RTYPEWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         BEQEX: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
         ADDIWB:  c.regwrite = 1'b1;
         JEX: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state selection from the current state and opcode
   always_comb begin
      next_state_s = next_state(state_r, op);
   end

   // State register; controls are registered from the next state so they stay Moore
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= FETCH;
         ctrl_r  <= state_ctrl(FETCH);
      end else begin
         state_r <= next_state_s;
         ctrl_r  <= state_ctrl(next_state_s);
      end
   end

   // ALU decoder; unknown funct and the unused aluop fall back to add
   always_comb begin
      alucontrol = 3'b010;
      case (ctrl_r.aluop)
         2'b00: alucontrol = 3'b010;
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   assign pcen     = ctrl_r.pcwrite | (ctrl_r.branch & zero);
   assign memwrite = ctrl_r.memwrite;
   assign irwrite  = ctrl_r.irwrite;
   assign regwrite = ctrl_r.regwrite;
   assign alusrca  = ctrl_r.alusrca;
   assign alusrcb  = ctrl_r.alusrcb;
   assign iord     = ctrl_r.iord;
   assign memtoreg = ctrl_r.memtoreg;
   assign regdst   = ctrl_r.regdst;
   assign pcsrc    = ctrl_r.pcsrc;

endmodule
